// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter producing the registered 2-bit select for the downstream 4:1 mux.
// A grant is held until acked; the pointer rotates past the acked channel so no requester starves.

module rr_arb_cell #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] base,
  output logic             win
);
  localparam logic [SEL_W-1:0] IDX_W = SEL_W'(IDX);

  logic [SEL_W-1:0] rank;
  logic [SEL_W-1:0] ch;

  // Rank is this channel's distance from the scan start; any set request
  // with a smaller distance beats it.
  always_comb begin
    rank = IDX_W - base;
    win  = req[IDX];
    ch   = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch = base + SEL_W'(k);
      if ((SEL_W'(k) < rank) && req[ch]) win = 1'b0;
    end
  end
endmodule

module rr_select_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             ack,
  output logic [SEL_W-1:0] cs,
  output logic [N_CH-1:0]  gnt,
  output logic             gnt_valid
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cs_nxt_ptr;
  logic [SEL_W-1:0] base;
  logic [N_CH-1:0]  win;
  logic [SEL_W-1:0] win_idx;
  logic             any_req;

  assign cs_nxt_ptr = cs + SEL_W'(1);
  // On an ack the scan starts just past the channel being released, so the
  // back-to-back winner already uses the rotated pointer.
  assign base       = (state == GRANT) ? cs_nxt_ptr : ptr;
  assign any_req    = |req;

  for (genvar i = 0; i < N_CH; i++) begin : g_cell
    rr_arb_cell #(.N_CH(N_CH), .SEL_W(SEL_W), .IDX(i)) u_cell (
      .req  (req),
      .base (base),
      .win  (win[i])
    );
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (win[i]) win_idx = SEL_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cs        <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cs        <= win_idx;
            gnt       <= win;
            gnt_valid <= 1'b1;
            state     <= GRANT;
          end
        end
        default: begin
          if (ack) begin
            ptr <= cs_nxt_ptr;
            if (any_req) begin
              cs  <= win_idx;
              gnt <= win;
            end else begin
              gnt       <= '0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rr_select_arbiter.sv
// Randomized and directed checks of rr_select_arbiter against a scan-order reference model.

module tb_rr_select_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       ack = 1'b0;
  logic [1:0] cs;
  logic [3:0] gnt;
  logic       gnt_valid;

  int nvec = 0;
  int errs = 0;

  int m_ptr = 0;
  int m_cs = 0;
  bit m_valid = 1'b0;

  rr_select_arbiter #(.N_CH(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .cs        (cs),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++)
      if (r[(p + off) % 4]) return (p + off) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    return m_valid ? 4'(1 << m_cs) : 4'b0000;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cs = 0; m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, settle past it.
  task automatic step(input logic [3:0] r, input logic a);
    req = r; ack = a;
    @(posedge clk);
    if (!m_valid) begin
      if (r != 4'b0) begin m_cs = pick(r, m_ptr); m_valid = 1'b1; end
    end else if (a) begin
      m_ptr = (m_cs + 1) % 4;
      if (r != 4'b0) m_cs = pick(r, m_ptr);
      else m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    req = 4'b1111;
    #12;
    nvec++;
    if (cs !== 2'd0 || gnt !== 4'b0 || gnt_valid !== 1'b0) begin
      errs++; $display("FAIL reset_assert: cs=%0d gnt=%b vld=%b expected 0 0000 0", cs, gnt, gnt_valid);
    end
    req = 4'b0000;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b0);
      nvec++;
      if (cs !== 2'd0 || gnt !== 4'b0 || gnt_valid !== 1'b0) begin
        errs++; $display("FAIL reset_idle[%0d]: cs=%0d gnt=%b vld=%b expected 0 0000 0", i, cs, gnt, gnt_valid);
      end
    end
  endtask

  task automatic test_single_hold();
    step(4'b0100, 1'b0);
    nvec++;
    if (cs !== 2'd2 || gnt !== 4'b0100 || gnt_valid !== 1'b1) begin
      errs++; $display("FAIL single_grant: cs=%0d gnt=%b vld=%b expected 2 0100 1", cs, gnt, gnt_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b0);
      nvec++;
      if (cs !== 2'd2 || gnt !== 4'b0100 || gnt_valid !== 1'b1) begin
        errs++; $display("FAIL grant_hold[%0d]: cs=%0d gnt=%b vld=%b expected 2 0100 1", i, cs, gnt, gnt_valid);
      end
    end
    step(4'b0000, 1'b1);
    nvec++;
    if (cs !== 2'd2 || gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      errs++; $display("FAIL release_idle: cs=%0d gnt=%b vld=%b expected 2 0000 0", cs, gnt, gnt_valid);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] seq [6];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, 1'b1);
      nvec++;
      if (cs !== seq[i] || gnt_valid !== 1'b1 || gnt !== 4'(1 << seq[i])) begin
        errs++; $display("FAIL rotation[%0d]: cs=%0d gnt=%b vld=%b expected cs=%0d vld=1", i, cs, gnt, gnt_valid, seq[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] seq [3];
    seq = '{2'd0, 2'd3, 2'd0};
    step(4'b1000, 1'b1);
    nvec++;
    if (cs !== 2'd3 || gnt_valid !== 1'b1) begin
      errs++; $display("FAIL wrap_setup: cs=%0d vld=%b expected 3 1", cs, gnt_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b1001, 1'b1);
      nvec++;
      if (cs !== seq[i] || gnt !== 4'(1 << seq[i]) || gnt_valid !== 1'b1) begin
        errs++; $display("FAIL wrap[%0d]: cs=%0d gnt=%b vld=%b expected cs=%0d", i, cs, gnt, gnt_valid, seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(4'b0010, 1'b0);
    nvec++;
    if (cs !== 2'd1 || gnt_valid !== 1'b1) begin
      errs++; $display("FAIL midrst_setup: cs=%0d vld=%b expected 1 1", cs, gnt_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (cs !== 2'd0 || gnt !== 4'b0 || gnt_valid !== 1'b0) begin
      errs++; $display("FAIL midrst_async: cs=%0d gnt=%b vld=%b expected 0 0000 0", cs, gnt, gnt_valid);
    end
    #1 rst_n = 1'b1;
    model_reset();
    step(4'b0011, 1'b0);
    nvec++;
    if (cs !== 2'd0 || gnt !== 4'b0001 || gnt_valid !== 1'b1) begin
      errs++; $display("FAIL midrst_restart: cs=%0d gnt=%b vld=%b expected 0 0001 1", cs, gnt, gnt_valid);
    end
  endtask

  task automatic test_mux();
    logic [1:0] mux_in [4];
    logic [1:0] exp_out [8];
    logic [1:0] out;
    mux_in  = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_out = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1010, (i % 2 == 0) && (i > 0));
      out = mux_in[cs];
      nvec++;
      if (out !== exp_out[i] || gnt_valid !== 1'b1) begin
        errs++; $display("FAIL mux_out[%0d]: out=%0d vld=%b expected %0d 1", i, out, gnt_valid, exp_out[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       a;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      a = 1'($urandom_range(0, 1));
      step(r, a);
      nvec++;
      if (gnt_valid !== m_valid || gnt !== exp_gnt() || cs !== 2'(m_cs)) begin
        errs++; $display("FAIL random[%0d]: cs=%0d gnt=%b vld=%b expected cs=%0d gnt=%b vld=%b",
                         i, cs, gnt, gnt_valid, m_cs, exp_gnt(), m_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_rotation();
    test_wrap();
    test_reset_mid();
    test_mux();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
